// File: rtl/sha3_sched_pkg.sv
// Shared encodings for the SHA-3 job scheduler: core modes, sponge rates, digest sizes, FSM states.
package sha3_sched_pkg;

  localparam logic [1:0] MODE_SHA3_256 = 2'b00;
  localparam logic [1:0] MODE_SHA3_512 = 2'b01;
  localparam logic [1:0] MODE_SHAKE128 = 2'b10;
  localparam logic [1:0] MODE_SHAKE256 = 2'b11;

  localparam logic [7:0] RATE_136 = 8'd136;
  localparam logic [7:0] RATE_72  = 8'd72;
  localparam logic [7:0] RATE_168 = 8'd168;

  localparam int DIGEST_256_LEN = 32;
  localparam int DIGEST_512_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ABSORB,
    ST_SQUEEZE,
    ST_DONE
  } state_e;

  function automatic logic [7:0] mode_rate(input logic [1:0] mode);
    case (mode)
      MODE_SHA3_512: return RATE_72;
      MODE_SHAKE128: return RATE_168;
      default:       return RATE_136;
    endcase
  endfunction

endpackage

// File: rtl/sha3_job_scheduler_if.sv
// Requester-side and core-side signals of the SHA-3 job scheduler, packed per requester.
interface sha3_job_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [2*N_REQ-1:0]     req_mode;
  logic [LEN_W*N_REQ-1:0] req_in_len;
  logic [LEN_W*N_REQ-1:0] req_out_len;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       in_valid;
  logic [8*N_REQ-1:0]     in_data;
  logic [N_REQ-1:0]       in_ready;
  logic [7:0]             out_data;
  logic [N_REQ-1:0]       out_valid;
  logic                   out_last;
  logic [N_REQ-1:0]       done;
  logic [1:0]             core_sel;
  logic [7:0]             core_in;
  logic                   core_in_go;
  logic                   core_flag;
  logic                   core_in_ready;
  logic                   core_out_go;
  logic [7:0]             core_out;
  logic                   core_next;
  logic                   core_abort;

  modport master (
    output req_valid, req_mode, req_in_len, req_out_len, in_valid, in_data,
           core_in_ready, core_out_go, core_out,
    input  req_ready, grant, in_ready, out_data, out_valid, out_last, done,
           core_sel, core_in, core_in_go, core_flag, core_next, core_abort
  );

  modport slave (
    input  req_valid, req_mode, req_in_len, req_out_len, in_valid, in_data,
           core_in_ready, core_out_go, core_out,
    output req_ready, grant, in_ready, out_data, out_valid, out_last, done,
           core_sel, core_in, core_in_go, core_flag, core_next, core_abort
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins, one-hot result.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o
);

  // Walk from the farthest offset back to ptr_i so the nearest requester overwrites last.
  always_comb begin
    gnt_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha3_job_scheduler.sv
// Shares one SHA-3/SHAKE core among N_REQ requesters; req_ready 2 cycles after request, byte paths
// are combinational; input follows core_in_ready, output cannot be stalled by requesters.
module sha3_job_scheduler
  import sha3_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  sha3_job_scheduler_if.slave sif
);

  localparam int PTR_W = $clog2(N_REQ);

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q, gidx_q;
  logic [N_REQ-1:0]   grant_q, req_ready_q, done_q;
  logic [1:0]         mode_q, core_sel_q;
  logic [LEN_W-1:0]   in_len_q, in_cnt_q, rem_q;
  logic [7:0]         blk_q;
  logic               core_next_q, core_abort_q;

  logic [N_REQ-1:0]   pick_d;
  logic [PTR_W-1:0]   pick_idx_d;
  logic [1:0]         pick_mode_d;
  logic [LEN_W-1:0]   pick_in_len_d, pick_rem_d;
  logic [N_REQ-1:0]   gnt_vec_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (sif.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_d)
  );

  always_comb begin
    pick_idx_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_d[i]) pick_idx_d = PTR_W'(i);
    end
  end

  assign pick_mode_d   = sif.req_mode[int'(pick_idx_d)*2 +: 2];
  assign pick_in_len_d = sif.req_in_len[int'(pick_idx_d)*LEN_W +: LEN_W];
  assign gnt_vec_d     = N_REQ'(1) << gidx_q;

  // Fixed-output modes ignore the requested out_len.
  always_comb begin
    case (pick_mode_d)
      MODE_SHA3_256: pick_rem_d = LEN_W'(DIGEST_256_LEN);
      MODE_SHA3_512: pick_rem_d = LEN_W'(DIGEST_512_LEN);
      default:       pick_rem_d = sif.req_out_len[int'(pick_idx_d)*LEN_W +: LEN_W];
    endcase
  end

  logic absorbing, empty_msg, in_xfer, last_in, out_xfer;
  assign absorbing = (state_q == ST_ABSORB);
  assign empty_msg = absorbing && (in_len_q == '0);
  assign in_xfer   = absorbing && !empty_msg && sif.in_valid[gidx_q] && sif.core_in_ready;
  assign last_in   = (in_cnt_q == in_len_q - LEN_W'(1));
  assign out_xfer  = (state_q == ST_SQUEEZE) && (rem_q != '0) && sif.core_out_go;

  assign sif.in_ready   = {N_REQ{absorbing && !empty_msg && sif.core_in_ready}} & grant_q;
  assign sif.core_in_go = in_xfer;
  assign sif.core_in    = absorbing ? sif.in_data[{gidx_q, 3'b000} +: 8] : 8'h00;
  assign sif.core_flag  = empty_msg || (in_xfer && last_in);
  assign sif.out_valid  = {N_REQ{out_xfer}} & grant_q;
  assign sif.out_data   = out_xfer ? sif.core_out : 8'h00;
  assign sif.out_last   = out_xfer && (rem_q == LEN_W'(1));
  assign sif.req_ready  = req_ready_q;
  assign sif.grant      = grant_q;
  assign sif.done       = done_q;
  assign sif.core_sel   = core_sel_q;
  assign sif.core_next  = core_next_q;
  assign sif.core_abort = core_abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gidx_q       <= '0;
      grant_q      <= '0;
      req_ready_q  <= '0;
      done_q       <= '0;
      mode_q       <= '0;
      core_sel_q   <= '0;
      in_len_q     <= '0;
      in_cnt_q     <= '0;
      rem_q        <= '0;
      blk_q        <= '0;
      core_next_q  <= 1'b0;
      core_abort_q <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      done_q       <= '0;
      core_next_q  <= 1'b0;
      core_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|sif.req_valid) begin
            gidx_q     <= pick_idx_d;
            mode_q     <= pick_mode_d;
            core_sel_q <= pick_mode_d;
            in_len_q   <= pick_in_len_d;
            rem_q      <= pick_rem_d;
            in_cnt_q   <= '0;
            blk_q      <= '0;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_ready_q <= gnt_vec_d;
          grant_q     <= gnt_vec_d;
          state_q     <= ST_ABSORB;
        end
        ST_ABSORB: begin
          if (empty_msg) begin
            state_q <= ST_SQUEEZE;
          end else if (in_xfer) begin
            in_cnt_q <= in_cnt_q + LEN_W'(1);
            if (last_in) state_q <= ST_SQUEEZE;
          end
        end
        ST_SQUEEZE: begin
          if (rem_q == '0) begin
            state_q <= ST_DONE;
          end else if (sif.core_out_go) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
            end else if ((mode_q inside {MODE_SHAKE128, MODE_SHAKE256}) &&
                         (blk_q + 8'd1 == mode_rate(mode_q))) begin
              core_next_q <= 1'b1;
              blk_q       <= '0;
            end else begin
              blk_q <= blk_q + 8'd1;
            end
          end
        end
        ST_DONE: begin
          done_q       <= grant_q;
          core_abort_q <= 1'b1;
          grant_q      <= '0;
          core_sel_q   <= '0;
          rr_ptr_q     <= (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_job_scheduler.sv
// Randomized bench for sha3_job_scheduler with a job-level reference model (pending set, RR order, byte counts).
module tb_sha3_job_scheduler;

  localparam int N  = 4;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha3_job_scheduler_if #(.N_REQ(N), .LEN_W(LW)) sif();
  sha3_job_scheduler #(.N_REQ(N), .LEN_W(LW)) dut (.clk(clk), .reset(reset), .sif(sif));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rr_ptr;
  bit pend [N];
  int jm [N];
  int jin [N];
  int jout [N];
  int t_post [N];
  bit bp_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int digest_len(input int m, input int ol);
    if (m == 0) return 32;
    if (m == 1) return 64;
    return ol;
  endfunction

  function automatic int rate_of(input int m);
    if (m == 1) return 72;
    if (m == 2) return 168;
    return 136;
  endfunction

  function automatic int predict();
    for (int i = 0; i < N; i++) begin
      if (pend[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic post_req(input int r, input int m, input int il, input int ol);
    sif.req_valid[r]             = 1'b1;
    sif.req_mode[2*r +: 2]       = 2'(m);
    sif.req_in_len[r*LW +: LW]   = LW'(il);
    sif.req_out_len[r*LW +: LW]  = LW'(ol);
    pend[r] = 1'b1; jm[r] = m; jin[r] = il; jout[r] = ol; t_post[r] = cyc;
  endtask

  task automatic serve_one(input int abort_after, input bit chk_lat, output int g, output bit aborted);
    bit got, fin, exp_go, exp_flag, exp_v;
    int t, sent, bytes, dut_bytes, lasts, nexts, exp_n, rt;
    aborted = 1'b0;
    g = predict();
    if (g < 0) begin chk("nothing_pending", 1, 0); return; end
    got = 1'b0;
    for (t = 0; t < 40 && !got; t++) begin
      @(negedge clk); #1;
      if (sif.req_ready != '0) got = 1'b1;
    end
    if (!got) begin chk("req_ready_timeout", 0, 1); return; end
    if (chk_lat) chk("req_latency", cyc - t_post[g], 2);
    chk("req_ready", sif.req_ready, 1 << g);
    chk("grant", sif.grant, 1 << g);
    chk("core_sel", sif.core_sel, jm[g]);
    sif.req_valid[g] = 1'b0;
    pend[g] = 1'b0;
    rr_ptr = (g + 1) % N;

    sent = 0; fin = 1'b0;
    for (t = 0; t < 3000 && !fin; t++) begin
      sif.in_valid = N'($urandom);
      if (!bp_mode) sif.in_valid[g] = 1'b1;
      sif.in_data       = (8*N)'($urandom);
      sif.core_in_ready = bp_mode ? 1'($urandom) : 1'b1;
      sif.core_out_go   = ($urandom % 4) == 0;
      sif.core_out      = 8'($urandom);
      #1;
      exp_go   = (jin[g] != 0) && (sent < jin[g]) && sif.in_valid[g] && sif.core_in_ready;
      exp_flag = (jin[g] == 0) ? 1'b1 : (exp_go && sent == jin[g] - 1);
      chk("core_in_go", sif.core_in_go, exp_go);
      chk("core_flag", sif.core_flag, exp_flag);
      chk("stray_out_valid", sif.out_valid, 0);
      if (jin[g] != 0) chk("in_ready", sif.in_ready, sif.core_in_ready ? (1 << g) : 0);
      if (exp_go) begin
        chk("core_in", sif.core_in, sif.in_data[8*g +: 8]);
        sent++;
      end
      if (exp_flag) fin = 1'b1;
      @(negedge clk); #1;
    end
    if (!fin) begin chk("absorb_timeout", 0, 1); return; end
    sif.in_valid = '0; sif.core_in_ready = 1'b0;

    exp_n = digest_len(jm[g], jout[g]);
    rt = rate_of(jm[g]);
    bytes = 0; dut_bytes = 0; lasts = 0; nexts = 0; fin = 1'b0;
    for (t = 0; t < 4000 && !fin; t++) begin
      if (sif.core_next) begin
        nexts++;
        chk("core_next_pos", (bytes > 0) && (bytes % rt == 0) && (bytes < exp_n), 1);
      end
      if (sif.done != '0) begin
        chk("done", sif.done, 1 << g);
        chk("core_abort", sif.core_abort, 1);
        chk("grant_clear", sif.grant, 0);
        chk("core_sel_idle", sif.core_sel, 0);
        fin = 1'b1;
      end else begin
        if (abort_after >= 0 && bytes == abort_after) begin
          aborted = 1'b1;
          sif.core_out_go = 1'b0;
          return;
        end
        chk("grant_hold", sif.grant, 1 << g);
        sif.core_out_go = bp_mode ? 1'($urandom) : 1'b1;
        sif.core_out    = 8'($urandom);
        #1;
        exp_v = sif.core_out_go && (bytes < exp_n);
        if (sif.out_valid[g]) dut_bytes++;
        chk("out_valid", sif.out_valid, exp_v ? (1 << g) : 0);
        if (exp_v) begin
          chk("out_data", sif.out_data, sif.core_out);
          bytes++;
          chk("out_last", sif.out_last, bytes == exp_n);
        end else begin
          chk("out_last_idle", sif.out_last, 0);
        end
        if (sif.out_last) lasts++;
        @(negedge clk); #1;
      end
    end
    sif.core_out_go = 1'b0;
    if (!fin) begin chk("squeeze_timeout", 0, 1); return; end
    chk("out_count", dut_bytes, exp_n);
    chk("last_count", lasts, exp_n > 0);
    chk("next_count", nexts, (jm[g] >= 2 && exp_n > 0) ? (exp_n - 1) / rt : 0);
  endtask

  function automatic logic [42:0] all_outs();
    return {sif.req_ready, sif.grant, sif.in_ready, sif.out_valid, sif.done, sif.out_data,
            sif.out_last, sif.core_sel, sif.core_in, sif.core_in_go, sif.core_flag,
            sif.core_next, sif.core_abort};
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int g;
    bit ab;
    bit any;
    sif.req_valid = '0; sif.req_mode = '0; sif.req_in_len = '0; sif.req_out_len = '0;
    sif.in_valid = '0; sif.in_data = '0; sif.core_in_ready = 1'b0;
    sif.core_out_go = 1'b0; sif.core_out = '0;
    bp_mode = 1'b0; rr_ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b0;

    // Round-robin from reset, requester 0 comes back during the others' jobs.
    post_req(0, 0, 2, 0);
    post_req(2, 2, 1, 10);
    post_req(3, 3, 0, 3);
    serve_one(-1, 1'b1, g, ab); chk("rr_order_0", g, 0);
    post_req(0, 1, 4, 0);
    serve_one(-1, 1'b0, g, ab); chk("rr_order_1", g, 2);
    serve_one(-1, 1'b0, g, ab); chk("rr_order_2", g, 3);
    serve_one(-1, 1'b0, g, ab); chk("rr_order_3", g, 0);

    // Single SHA3-256, 3-byte message.
    post_req(1, 0, 3, 0);
    serve_one(-1, 1'b1, g, ab);

    // SHAKE128 spanning three squeeze blocks.
    post_req(2, 2, 5, 400);
    serve_one(-1, 1'b1, g, ab);

    // Empty message, then zero-length SHAKE output.
    post_req(3, 3, 0, 5);
    serve_one(-1, 1'b1, g, ab);
    post_req(0, 2, 7, 0);
    serve_one(-1, 1'b1, g, ab);

    // Backpressure on both input handshake sides with stray core output.
    bp_mode = 1'b1;
    post_req(1, 1, 10, 0);
    serve_one(-1, 1'b1, g, ab);
    bp_mode = 1'b0;

    // Reset in the middle of a SHAKE256 squeeze.
    post_req(2, 3, 4, 100);
    serve_one(40, 1'b1, g, ab);
    chk("abort_reached", ab, 1);
    reset = 1'b1;
    sif.core_out_go = 1'b1; sif.in_valid = '1; sif.core_in_ready = 1'b1;
    @(negedge clk); #1;
    chk("reset_mid_squeeze", all_outs(), 0);
    reset = 1'b0;
    sif.core_out_go = 1'b0; sif.in_valid = '0; sif.core_in_ready = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rr_ptr = 0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("no_done_after_reset", {sif.done, sif.core_abort, sif.grant}, 0);
    end
    post_req(3, 0, 1, 0);
    post_req(0, 3, 2, 9);
    serve_one(-1, 1'b1, g, ab); chk("rr_after_reset", g, 0);
    serve_one(-1, 1'b0, g, ab); chk("rr_after_reset_2", g, 3);

    // Randomized batches of simultaneous requests.
    for (int round = 0; round < 8; round++) begin
      bp_mode = 1'($urandom);
      any = 1'b0;
      for (int r = 0; r < N; r++) begin
        if ($urandom % 2) begin
          post_req(r, int'($urandom % 4), int'($urandom % 20), int'($urandom % 320));
          any = 1'b1;
        end
      end
      if (!any) post_req(int'($urandom % N), 2, int'($urandom % 20), int'($urandom % 320));
      for (int k = 0; k < N && predict() >= 0; k++) serve_one(-1, 1'b0, g, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
